load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, legal 1..4: memory read latency in cycles from mem_en to valid mem_rdata.
REQ-002 SHALL have port aclk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port aresetn, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid, input, 1: core access request.
REQ-005 SHALL have port req_ready, output, 1: unit can accept a request.
REQ-006 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-007 SHALL have port req_size, input, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port req_unsigned, input, 1: loads only; 1 = zero-extend, 0 = sign-extend.
REQ-009 SHALL have port req_addr, input, 32: byte address.
REQ-010 SHALL have port req_wdata, input, 32: store data, right-aligned.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: core accepts the response.
REQ-013 SHALL have port rsp_rdata, output, 32: extended load data.
REQ-014 SHALL have port rsp_err, output, 1: misaligned or illegal access.
REQ-015 SHALL have port mem_addr, output, 30: word address, equal to req_addr[31:2].
REQ-016 SHALL have port mem_en, output, 1: memory enable.
REQ-017 SHALL have port mem_we, output, 4: byte write enables; bit i = byte lane i.
REQ-018 SHALL have port mem_wdata, output, 32: lane-replicated store data.
REQ-019 SHALL have port mem_rdata, input, 32: memory read data, little-endian.

Function
REQ-020 SHALL implement the FSM states IDLE, ACCESS, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-021 IDLE: on req_valid & req_ready, SHALL register addr, size, we, unsigned and wdata; if the access is misaligned, go to RESP with rsp_err = 1 and no memory access; otherwise go to ACCESS.
REQ-022 Misaligned SHALL mean: size 01 with addr[0] = 1; size 10 with addr[1:0] != 0; size 11 always.
REQ-023 ACCESS: mem_en = 1 for exactly one cycle; stores then go to RESP; loads go to WAIT.
REQ-024 mem_we in ACCESS SHALL be:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1], 1'b0}
  - word: 4'b1111
  - loads: 4'b0000
REQ-025 mem_wdata SHALL be:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
REQ-026 WAIT: a counter SHALL sample mem_rdata exactly RD_LAT cycles after the ACCESS cycle, then go to RESP.
REQ-027 Load extraction SHALL be:
  - byte: mem_rdata[8*addr[1:0] +: 8]
  - half: mem_rdata[16*addr[1] +: 16]
  - sign- or zero-extended to 32 per req_unsigned.
REQ-028 rsp_rdata SHALL be 0 for stores and for errors.
REQ-029 RESP: rsp_valid = 1 and rsp_rdata/rsp_err stable until rsp_ready; on rsp_valid & rsp_ready, return to IDLE.
REQ-030 Latency with rsp_ready held high, counting the handshake cycle as 0:
  - error: rsp_valid in cycle 1
  - store: rsp_valid in cycle 2
  - load: rsp_valid in cycle 2 + RD_LAT
REQ-031 mem_en, mem_we and mem_wdata SHALL be zero outside ACCESS; mem_addr holds the registered address.
REQ-032 Only one transaction SHALL be outstanding; req_valid outside IDLE SHALL be ignored, with no capture.
REQ-033 rsp_ready outside RESP SHALL have no effect.

Reset
REQ-034 While aresetn = 0, the unit SHALL be in state IDLE and all registers zero, giving these outputs:
  - req_ready = 1
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0
  - mem_en = 0, mem_we = 0, mem_wdata = 0, mem_addr = 0
REQ-035 Reset asserted mid-transaction (ACCESS, WAIT or RESP) SHALL drop it immediately; no write enable may be asserted after the reset edge.

Verification
REQ-036 Store byte: addr 0x103, wdata 0xA5 -> ACCESS shows mem_addr 0x40, mem_we 4'b1000, mem_wdata 0xA5A5A5A5; rsp_valid in cycle 2, rsp_err 0.
REQ-037 Load half signed: addr 0x6, mem_rdata 0x8001_1234, RD_LAT 2 -> rsp_rdata 0xFFFF8001 in cycle 4; repeated with req_unsigned = 1 -> 0x00008001.
REQ-038 Misaligned word: addr 0x2 -> mem_en never asserted; rsp_err 1 and rsp_rdata 0 in cycle 1; size 11 gives the same result.
REQ-039 Backpressure: rsp_ready held low for 5 cycles -> rsp_valid and rsp_rdata stable; a req_valid pulse during this time is not accepted.
REQ-040 Reset during WAIT -> outputs return to reset values asynchronously; the next load after reset completes normally.
REQ-041 Load byte lanes 0..3 of 0x80FF7F01 unsigned -> 0x01, 0x7F, 0xFF, 0x80; signed -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.

Source files
------------

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a core request/response port and a
// word-wide synchronous memory with a fixed read latency of RD_LAT cycles.
module load_store_unit #(
    parameter int RD_LAT = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [29:0] mem_addr,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

    localparam logic [2:0] RD_LAT_C = 3'(RD_LAT);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;
    logic [2:0]  cnt_q, cnt_d;

    logic        misaligned;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_ext;

    always_comb begin
        unique case (req_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    // Lane select and extension of the returned word, using the captured request.
    always_comb begin
        unique case (addr_q[1:0])
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        unique case (size_q)
            2'b00:   load_ext = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   load_ext = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: load_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                    rdata_d = 32'h0;
                    err_d   = misaligned;
                    cnt_d   = 3'd0;
                    state_d = misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = 3'd1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // cnt_q counts cycles since ACCESS; data is valid when it reaches RD_LAT.
                if (cnt_q == RD_LAT_C) begin
                    rdata_d = load_ext;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                if (rsp_ready) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign mem_addr  = addr_q[31:2];
    assign mem_en    = (state_q == ACCESS);

    always_comb begin
        mem_we    = 4'b0000;
        mem_wdata = 32'h0;
        if (state_q == ACCESS && we_q) begin
            unique case (size_q)
                2'b00: begin
                    mem_we    = 4'b0001 << addr_q[1:0];
                    mem_wdata = {4{wdata_q[7:0]}};
                end
                2'b01: begin
                    mem_we    = 4'b0011 << {addr_q[1], 1'b0};
                    mem_wdata = {2{wdata_q[15:0]}};
                end
                default: begin
                    mem_we    = 4'b1111;
                    mem_wdata = wdata_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses and
// memory accesses; independent monitors pop and compare them as the DUT presents them.
module tb_load_store_unit;

    localparam int RD_LAT = 2;

    logic        aclk;
    logic        aresetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [29:0] mem_addr;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    load_store_unit #(.RD_LAT(RD_LAT)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_addr(mem_addr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        int          t;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [29:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        is_store;
    } macc_t;

    rsp_t  exp_q[$];
    macc_t mem_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    logic  in_resp = 1'b0;
    rsp_t  cur;

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Memory model: RD_LAT-deep read pipeline, byte-enabled writes.
    logic [31:0] mem [0:255];
    logic [31:0] pipe [0:RD_LAT-1];
    assign mem_rdata = pipe[RD_LAT-1];

    initial begin
        logic        s_en;
        logic [3:0]  s_we;
        logic [7:0]  s_idx;
        logic [31:0] s_wd;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1]     = 32'h8001_1234;
        mem[2]     = 32'h80FF_7F01;
        mem[8'h40] = 32'h1122_3344;
        for (int i = 0; i < RD_LAT; i++) pipe[i] <= 32'hDEAD_BEEF;
        forever begin
            @(negedge aclk);
            s_en  = mem_en;
            s_we  = mem_we;
            s_idx = mem_addr[7:0];
            s_wd  = mem_wdata;
            @(posedge aclk);
            if (s_en) begin
                for (int b = 0; b < 4; b++)
                    if (s_we[b]) mem[s_idx][8*b +: 8] = s_wd[8*b +: 8];
            end
            pipe[0] <= (s_en && s_we == 4'b0000) ? mem[s_idx] : 32'hDEAD_BEEF;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // Response monitor.
    always @(negedge aclk) begin
        if (!aresetn) begin
            in_resp = 1'b0;
        end else if (rsp_valid) begin
            if (!in_resp) begin
                in_resp = 1'b1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got rsp_valid expected none (cycle %0d)", cyc);
                end else begin
                    cur = exp_q.pop_front();
                    $display("RSP cycle=%0d issued=%0d rdata=%h err=%b", cyc, cur.t, rsp_rdata, rsp_err);
                    chk("rsp_latency", 32'(cyc - cur.t), 32'(cur.lat));
                    chk("rsp_rdata", rsp_rdata, cur.rdata);
                    chk("rsp_err", {31'h0, rsp_err}, {31'h0, cur.err});
                end
            end else begin
                chk("rsp_rdata_hold", rsp_rdata, cur.rdata);
                chk("rsp_err_hold", {31'h0, rsp_err}, {31'h0, cur.err});
            end
            if (rsp_ready) in_resp = 1'b0;
        end
    end

    // Memory-side monitor.
    always @(negedge aclk) begin
        macc_t m;
        if (aresetn) begin
            if (mem_en) begin
                if (mem_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_en: got mem_en=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    m = mem_q.pop_front();
                    chk("mem_addr", {2'b00, mem_addr}, {2'b00, m.addr});
                    chk("mem_we", {28'h0, mem_we}, {28'h0, m.we});
                    if (m.is_store) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end else begin
                chk("mem_we_idle", {28'h0, mem_we}, 32'h0);
                chk("mem_wdata_idle", mem_wdata, 32'h0);
            end
        end
    end

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_we, input logic [31:0] exp_wdata);
        int   n = 0;
        rsp_t r;
        macc_t m;
        @(posedge aclk); #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        while (!req_ready && n < 100) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("req_accept_timeout", {31'h0, req_ready}, 32'h1);
        r.t     = cyc;
        r.lat   = exp_err ? 1 : (we ? 2 : 2 + RD_LAT);
        r.rdata = exp_rdata;
        r.err   = exp_err;
        exp_q.push_back(r);
        if (!exp_err) begin
            m.addr     = addr[31:2];
            m.we       = exp_we;
            m.wdata    = exp_wdata;
            m.is_store = we;
            mem_q.push_back(m);
        end
        @(posedge aclk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_resp) && n < 200) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("drain_timeout", {31'h0, (n < 200)}, 32'h1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, {31'h0, req_ready}, 32'h1);
        chk({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h0);
        chk({tag, "_rsp_err"},   {31'h0, rsp_err},   32'h0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk({tag, "_mem_en"},    {31'h0, mem_en},    32'h0);
        chk({tag, "_mem_we"},    {28'h0, mem_we},    32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_mem_addr"},  {2'b00, mem_addr},  32'h0);
    endtask

    logic [31:0] lane_u [4];
    logic [31:0] lane_s [4];

    initial begin
        int n;
        lane_u = '{32'h0000_0001, 32'h0000_007F, 32'h0000_00FF, 32'h0000_0080};
        lane_s = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80};
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        aresetn = 1'b1;
        #1 aresetn = 1'b0;
        #11 chk_reset("reset");
        @(negedge aclk); #2 aresetn = 1'b1;

        // Byte store into lane 3 of word 0x40.
        issue(1'b1, 2'b00, 1'b0, 32'h103, 32'h0000_00A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5_A5A5);
        // Halfword loads, signed then unsigned.
        issue(1'b0, 2'b01, 1'b0, 32'h6, 32'h0, 32'hFFFF_8001, 1'b0, 4'b0000, 32'h0);
        issue(1'b0, 2'b01, 1'b1, 32'h6, 32'h0, 32'h0000_8001, 1'b0, 4'b0000, 32'h0);
        // Misaligned and illegal accesses never touch memory.
        issue(1'b0, 2'b10, 1'b0, 32'h2, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'b0000, 32'h0);
        // All byte lanes, zero- and sign-extended.
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'b00, 1'b1, 32'h8 + 32'(i), 32'h0, lane_u[i], 1'b0, 4'b0000, 32'h0);
            issue(1'b0, 2'b00, 1'b0, 32'h8 + 32'(i), 32'h0, lane_s[i], 1'b0, 4'b0000, 32'h0);
        end
        // Stores observed through later loads.
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hA522_3344, 1'b0, 4'b0000, 32'h0);
        issue(1'b1, 2'b01, 1'b0, 32'h100, 32'h1234_CAFE, 32'h0, 1'b0, 4'b0011, 32'hCAFE_CAFE);
        issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF);
        issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hBEEF_CAFE, 1'b0, 4'b0000, 32'h0);
        issue(1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'hFFFF_BEEF, 1'b0, 4'b0000, 32'h0);
        issue(1'b1, 2'b10, 1'b0, 32'h104, 32'h1234_5678, 32'h0, 1'b0, 4'b1111, 32'h1234_5678);
        issue(1'b0, 2'b10, 1'b0, 32'h104, 32'h0, 32'h1234_5678, 1'b0, 4'b0000, 32'h0);
        drain();

        // Backpressure: response held for 5 cycles, stray request ignored.
        rsp_ready = 1'b0;
        issue(1'b0, 2'b00, 1'b0, 32'hB, 32'h0, 32'hFFFF_FF80, 1'b0, 4'b0000, 32'h0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(posedge aclk); #1;
            n++;
        end
        chk("bp_rsp_timeout", {31'h0, rsp_valid}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
                req_addr = 32'h0; req_wdata = 32'hFFFF_FFFF;
                chk("bp_req_ready", {31'h0, req_ready}, 32'h0);
            end else begin
                req_valid = 1'b0;
            end
            @(posedge aclk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 4'b0000, 32'h0);
        drain();

        // Reset while waiting for read data, then a normal load.
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8001_1234, 1'b0, 4'b0000, 32'h0);
        @(posedge aclk); #1;
        #1 aresetn = 1'b0;
        exp_q.delete();
        mem_q.delete();
        #1 chk_reset("reset_wait");
        @(negedge aclk); #2 aresetn = 1'b1;
        issue(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 32'h8001_1234, 1'b0, 4'b0000, 32'h0);
        drain();
        chk("mem_q_empty", 32'(mem_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
